// File: rtl/sswfmcw_pkg.sv
// Shared definitions for the beat-signal CIC decimator.
// Holds the default decimation ratio and output width, the CIC accumulator
// width and stage count, the warm-up state enumeration, and the PDM mixer
// helper that turns a microphone bit and a LO sign bit into a +/-1 sample.
package sswfmcw_pkg;

  localparam int C_DECIM_DEF = 64;
  localparam int C_PCM_W_DEF = 16;
  localparam int ACC_W       = 20;
  localparam int N_STAGES    = 3;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } warm_state_t;

  // d*l is +1 exactly when the mic bit and the LO sign bit differ
  // (mic 1 = +1, LO sign 1 = -1), otherwise -1.
  function automatic acc_t mix_sample(input logic dat, input logic lo_sign);
    return (dat ^ lo_sign) ? acc_t'(1) : acc_t'(-1);
  endfunction

endpackage

// File: rtl/beat_cic_decim_if.sv
// Bundle of the decimator's data-path signals.
// master: the decimator (takes mic/LO/sync strobes, drives the PCM stream)
// slave : the surrounding system (drives mic/LO/sync, consumes PCM)
//   MIC_EE_i     mic sample strobe        MIC_DAT_i   PDM bit
//   LO_SIGN_i    transmit cosine sign     SWEEP_SYNC_i chirp turnaround pulse
//   PCM_o        signed beat sample       PCM_VALID_o sample pending
//   PCM_READY_i  consumer accepts PCM_o   OVF_o       sticky overwrite flag
interface beat_cic_decim_if
  import sswfmcw_pkg::*;
#(
  parameter int C_PCM_W = C_PCM_W_DEF
);

  logic                      MIC_EE_i;
  logic                      MIC_DAT_i;
  logic                      LO_SIGN_i;
  logic                      SWEEP_SYNC_i;
  logic signed [C_PCM_W-1:0] PCM_o;
  logic                      PCM_VALID_o;
  logic                      PCM_READY_i;
  logic                      OVF_o;

  modport master (
    input  MIC_EE_i, MIC_DAT_i, LO_SIGN_i, SWEEP_SYNC_i, PCM_READY_i,
    output PCM_o, PCM_VALID_o, OVF_o
  );

  modport slave (
    output MIC_EE_i, MIC_DAT_i, LO_SIGN_i, SWEEP_SYNC_i, PCM_READY_i,
    input  PCM_o, PCM_VALID_o, OVF_o
  );

endinterface

// File: rtl/cic_comb.sv
// One CIC comb stage with differential delay 1: on each enabled cycle the
// output register takes (input - previous input) and the delay register
// takes the input. All arithmetic wraps modulo 2^ACC_W.
//   i_clk  clock             i_rst  synchronous reset
//   i_clr  synchronous clear (sweep resync)
//   i_en   stage enable      i_dat  stage input
//   o_dat  registered difference
module cic_comb
  import sswfmcw_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  acc_t i_dat,
  output acc_t o_dat
);

  acc_t r_dly;
  acc_t r_out;

  // Delay and difference registers; reset and resync both zero them so a new
  // sweep starts from a clean comb history.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_dly <= '0;
      r_out <= '0;
    end else if (i_en) begin
      r_out <= i_dat - r_dly;
      r_dly <= i_dat;
    end
  end

  assign o_dat = r_out;

endmodule

// File: rtl/beat_cic_decim.sv
// Beat-signal extractor for an FMCW sonar: mixes the PDM mic stream with the
// transmit cosine sign and decimates through a 3-stage CIC.
//   CK_i    system clock (48 MHz), rising edge only
//   SRST_i  synchronous active-high reset
//   bus     beat_cic_decim_if.master (mic/LO/sync in, PCM handshake out)
// The integrators feed their next values to the first comb stage, so the
// first comb fires on the decimation strobe itself and the result lands in
// the output register three cycles after the strobe edge.
module beat_cic_decim
  import sswfmcw_pkg::*;
#(
  parameter int C_DECIM = C_DECIM_DEF,
  parameter int C_PCM_W = C_PCM_W_DEF
)(
  input logic              CK_i,
  input logic              SRST_i,
  beat_cic_decim_if.master bus
);

  localparam int CNT_W = (C_DECIM > 1) ? $clog2(C_DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_DECIM - 1);

  logic [CNT_W-1:0]          r_cnt;
  acc_t                      r_integ1, r_integ2, r_integ3;
  acc_t                      w_x, w_integ1Nxt, w_integ2Nxt, w_integ3Nxt;
  warm_state_t               r_state;
  logic [N_STAGES-1:0]       r_stb;
  logic [N_STAGES-1:0]       r_pub;
  logic [N_STAGES-1:0]       w_combEn;
  acc_t                      w_comb [N_STAGES+1];
  logic signed [C_PCM_W-1:0] r_pcm;
  logic                      r_valid;
  logic                      r_ovf;
  logic                      w_ee, w_decStb, w_load, w_xfer;
  logic                      w_unusedBits;

  // A resync in the same cycle as a mic strobe drops that mic bit.
  assign w_ee     = bus.MIC_EE_i & ~bus.SWEEP_SYNC_i;
  assign w_decStb = w_ee & (r_cnt == CNT_LAST);
  assign w_x      = mix_sample(bus.MIC_DAT_i, bus.LO_SIGN_i);

  assign w_integ1Nxt = r_integ1 + w_x;
  assign w_integ2Nxt = r_integ2 + w_integ1Nxt;
  assign w_integ3Nxt = r_integ3 + w_integ2Nxt;

  // Integrators and decimation counter advance only on accepted mic strobes.
  always_ff @(posedge CK_i) begin
    if (SRST_i || bus.SWEEP_SYNC_i) begin
      r_cnt    <= '0;
      r_integ1 <= '0;
      r_integ2 <= '0;
      r_integ3 <= '0;
    end else if (w_ee) begin
      r_integ1 <= w_integ1Nxt;
      r_integ2 <= w_integ2Nxt;
      r_integ3 <= w_integ3Nxt;
      r_cnt    <= w_decStb ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Warm-up FSM plus comb pipeline tags. r_stb walks the strobe through the
  // comb stages; r_pub remembers whether that strobe was taken in RUN and so
  // may be published.
  always_ff @(posedge CK_i) begin
    if (SRST_i || bus.SWEEP_SYNC_i) begin
      r_state <= WARM0;
      r_stb   <= '0;
      r_pub   <= '0;
    end else begin
      r_stb <= {r_stb[N_STAGES-2:0], w_decStb};
      r_pub <= {r_pub[N_STAGES-2:0], w_decStb && (r_state == RUN)};
      if (w_decStb) begin
        case (r_state)
          WARM0:   r_state <= WARM1;
          WARM1:   r_state <= RUN;
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign w_comb[0] = w_integ3Nxt;
  assign w_combEn  = {r_stb[N_STAGES-2:0], w_decStb};

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    cic_comb u_comb (
      .i_clk (CK_i),
      .i_rst (SRST_i),
      .i_clr (bus.SWEEP_SYNC_i),
      .i_en  (w_combEn[g]),
      .i_dat (w_comb[g]),
      .o_dat (w_comb[g+1])
    );
  end

  assign w_load = r_stb[N_STAGES-1] & r_pub[N_STAGES-1] & ~bus.SWEEP_SYNC_i;
  assign w_xfer = r_valid & bus.PCM_READY_i;

  // Output register and handshake. A load over an untaken sample overwrites
  // it and latches OVF; a load coinciding with a transfer is a clean hand-off.
  // Resync never touches a pending sample.
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      r_pcm   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_pcm   <= w_comb[N_STAGES][ACC_W-1 -: C_PCM_W];
      r_valid <= 1'b1;
      if (r_valid && !bus.PCM_READY_i) begin
        r_ovf <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Truncated LSBs of the last comb are intentionally dropped.
  assign w_unusedBits = ^w_comb[N_STAGES];

  assign bus.PCM_o       = r_pcm;
  assign bus.PCM_VALID_o = r_valid;
  assign bus.OVF_o       = r_ovf;

endmodule
